// File: rtl/main_mem_loader_pkg.sv
// Shared types and constants for the board-side loader in front of the HLS core 'main'.
// Both the sequencer and its slave-port access engine import this package.
package main_mem_loader_pkg;

    localparam int SLV_CHANNELS     = 2;
    localparam int BYTE_ACCESS_SIZE = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WR_WAIT,
        ST_START,
        ST_RUN,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_OUT
    } state_t;

    typedef enum logic {
        ACC_IDLE,
        ACC_WAIT
    } acc_state_t;

endpackage

// File: rtl/main_mem_loader_slave_access.sv
// One-byte read/write on slave channel 0. The strobe is driven in the request cycle itself,
// then the engine waits up to MEM_TMO cycles for the data-ready acknowledge.
module main_slave_byte_access
    import main_mem_loader_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 64,
    parameter int SIZE_W  = 7,
    parameter int MEM_TMO = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [SIZE_W-1:0] mem_size,
    input  logic              data_rdy,
    output logic              ack,
    output logic              timeout
);
    localparam int TW = $clog2(MEM_TMO) + 1;

    acc_state_t      state_reg, state_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic            expired;

    assign expired = (timer_reg == TW'(MEM_TMO - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ACC_IDLE;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        case (state_reg)
            ACC_IDLE: if (req) begin
                state_next = ACC_WAIT;
                timer_next = '0;
            end
            ACC_WAIT: if (data_rdy || expired) state_next = ACC_IDLE;
                      else timer_next = timer_reg + TW'(1);
            default:  state_next = ACC_IDLE;
        endcase
    end

    // Address and size stay at zero whenever neither strobe is high.
    always_comb begin
        mem_oe    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_size  = '0;
        ack       = 1'b0;
        timeout   = 1'b0;
        if (state_reg == ACC_IDLE && req) begin
            mem_we    = wr;
            mem_oe    = !wr;
            mem_addr  = addr;
            mem_wdata = DATA_W'(wdata);
            mem_size  = SIZE_W'(BYTE_ACCESS_SIZE);
        end
        if (state_reg == ACC_WAIT) begin
            ack     = data_rdy;
            timeout = !data_rdy && expired;
        end
    end

endmodule

// File: rtl/main_mem_loader.sv
// Loads MEM_var of the HLS core through its slave port, runs the core and times it,
// then streams the memory back out byte by byte.
module main_mem_loader
    import main_mem_loader_pkg::*;
#(
    parameter int          NBYTES    = 256,
    parameter int          BASE_ADDR = 0,
    parameter int          ADDR_W    = 10,
    parameter int          DATA_W    = 64,
    parameter int          SIZE_W    = 7,
    parameter int          MEM_TMO   = 16,
    parameter int unsigned RUN_TMO   = 200000000
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             go,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [7:0]                       in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [7:0]                       out_data,
    output logic                             out_last,
    output logic                             busy,
    output logic                             error,
    output logic [31:0]                      cycles,
    output logic                             start_port,
    input  logic                             done_port,
    output logic [SLV_CHANNELS-1:0]          S_oe_ram,
    output logic [SLV_CHANNELS-1:0]          S_we_ram,
    output logic [SLV_CHANNELS*ADDR_W-1:0]   S_addr_ram,
    output logic [SLV_CHANNELS*DATA_W-1:0]   S_Wdata_ram,
    output logic [SLV_CHANNELS*SIZE_W-1:0]   S_data_ram_size,
    input  logic [SLV_CHANNELS*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [SLV_CHANNELS-1:0]          Sout_DataRdy
);
    localparam int            KW     = $clog2(NBYTES + 1);
    localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

    if (BASE_ADDR + NBYTES > (1 << ADDR_W)) begin : g_addr_range_check
        $error("main_mem_loader: BASE_ADDR + NBYTES does not fit in ADDR_W address bits");
    end

    state_t              state_reg, state_next;
    logic [KW-1:0]       k_reg;
    logic [31:0]         cycles_reg;
    logic                error_reg;
    logic [7:0]          out_data_reg;
    logic                acc_req, acc_wr, acc_ack, acc_timeout, run_timeout;
    logic [ADDR_W-1:0]   acc_addr;
    logic                ch0_oe, ch0_we;
    logic [ADDR_W-1:0]   ch0_addr;
    logic [DATA_W-1:0]   ch0_wdata;
    logic [SIZE_W-1:0]   ch0_size;
    logic                unused_inputs;

    assign unused_inputs = ^{Sout_Rdata_ram[SLV_CHANNELS*DATA_W-1:8], Sout_DataRdy[SLV_CHANNELS-1:1]};
    assign acc_addr      = ADDR_W'(BASE_ADDR) + ADDR_W'(k_reg);
    assign run_timeout   = (state_reg == ST_RUN) && !done_port && (cycles_reg >= RUN_TMO);

    always_ff @(posedge clock) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            k_reg        <= '0;
            cycles_reg   <= '0;
            error_reg    <= 1'b0;
            out_data_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE:    if (go) begin
                    error_reg <= 1'b0;
                    k_reg     <= '0;
                end
                ST_WR_WAIT: begin
                    if (acc_ack)     k_reg     <= k_reg + KW'(1);
                    if (acc_timeout) error_reg <= 1'b1;
                end
                ST_START:   cycles_reg <= '0;
                ST_RUN: begin
                    // The cycle in which done_port is seen is counted too.
                    if (cycles_reg != 32'hFFFF_FFFF) cycles_reg <= cycles_reg + 32'd1;
                    if (done_port)   k_reg     <= '0;
                    if (run_timeout) error_reg <= 1'b1;
                end
                ST_RD_WAIT: begin
                    if (acc_ack)     out_data_reg <= Sout_Rdata_ram[7:0];
                    if (acc_timeout) error_reg    <= 1'b1;
                end
                ST_OUT:     if (out_ready) k_reg <= k_reg + KW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (go) state_next = ST_LOAD;
            ST_LOAD:    if (in_valid) state_next = ST_WR_WAIT;
            ST_WR_WAIT: if (acc_timeout) state_next = ST_IDLE;
                        else if (acc_ack) state_next = (k_reg == K_LAST) ? ST_START : ST_LOAD;
            ST_START:   state_next = ST_RUN;
            ST_RUN:     if (done_port) state_next = ST_RD_REQ;
                        else if (run_timeout) state_next = ST_IDLE;
            ST_RD_REQ:  state_next = ST_RD_WAIT;
            ST_RD_WAIT: if (acc_timeout) state_next = ST_IDLE;
                        else if (acc_ack) state_next = ST_OUT;
            ST_OUT:     if (out_ready) state_next = (k_reg == K_LAST) ? ST_IDLE : ST_RD_REQ;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_reg == ST_LOAD);
        out_valid  = (state_reg == ST_OUT);
        out_last   = (state_reg == ST_OUT) && (k_reg == K_LAST);
        busy       = (state_reg != ST_IDLE);
        start_port = (state_reg == ST_START);
        acc_req    = ((state_reg == ST_LOAD) && in_valid) || (state_reg == ST_RD_REQ);
        acc_wr     = (state_reg == ST_LOAD);
    end

    assign error    = error_reg;
    assign cycles   = cycles_reg;
    assign out_data = out_data_reg;

    main_slave_byte_access #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .SIZE_W  (SIZE_W),
        .MEM_TMO (MEM_TMO)
    ) u_access (
        .clock     (clock),
        .reset     (reset),
        .req       (acc_req),
        .wr        (acc_wr),
        .addr      (acc_addr),
        .wdata     (in_data),
        .mem_oe    (ch0_oe),
        .mem_we    (ch0_we),
        .mem_addr  (ch0_addr),
        .mem_wdata (ch0_wdata),
        .mem_size  (ch0_size),
        .data_rdy  (Sout_DataRdy[0]),
        .ack       (acc_ack),
        .timeout   (acc_timeout)
    );

    genvar gi;
    for (gi = 0; gi < SLV_CHANNELS; gi++) begin : g_chan
        if (gi == 0) begin : g_used
            assign S_oe_ram[gi]                          = ch0_oe;
            assign S_we_ram[gi]                          = ch0_we;
            assign S_addr_ram[gi*ADDR_W +: ADDR_W]       = ch0_addr;
            assign S_Wdata_ram[gi*DATA_W +: DATA_W]      = ch0_wdata;
            assign S_data_ram_size[gi*SIZE_W +: SIZE_W]  = ch0_size;
        end else begin : g_tied
            assign S_oe_ram[gi]                          = 1'b0;
            assign S_we_ram[gi]                          = 1'b0;
            assign S_addr_ram[gi*ADDR_W +: ADDR_W]       = '0;
            assign S_Wdata_ram[gi*DATA_W +: DATA_W]      = '0;
            assign S_data_ram_size[gi*SIZE_W +: SIZE_W]  = '0;
        end
    end

endmodule

// File: tb/tb_main_mem_loader.sv
// Directed bench for main_mem_loader: a small core/memory model answers the slave port and
// done_port, and each step checks the loader's outputs against hand-derived values.
module tb_main_mem_loader;
    localparam int NB = 256;
    localparam int AW = 10;
    localparam int DW = 64;
    localparam int SW = 7;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            go = 1'b0;
    logic            in_valid = 1'b0;
    logic [7:0]      in_data = 8'h00;
    logic            out_ready = 1'b0;
    logic            in_ready, out_valid, out_last, busy, error, start_port, done_port;
    logic [7:0]      out_data;
    logic [31:0]     cycles;
    logic [1:0]      S_oe_ram, S_we_ram, Sout_DataRdy;
    logic [2*AW-1:0] S_addr_ram;
    logic [2*DW-1:0] S_Wdata_ram, Sout_Rdata_ram;
    logic [2*SW-1:0] S_data_ram_size;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem     [0:1023];
    logic [7:0] exp_mem [0:NB-1];
    int   wr_idx = 0, rd_idx = 0, rdy_delay = 2, done_delay = 5, block_wr = -1;
    int   pend = 0, run_cnt = -1;
    bit   pend_blk = 0;
    logic model_rdy = 1'b0, model_done = 1'b0, extra_done = 1'b0;
    logic [7:0] rbyte = 8'h00;

    assign done_port      = model_done | extra_done;
    assign Sout_DataRdy   = {1'b0, model_rdy};
    assign Sout_Rdata_ram = {64'hFFFF_FFFF_FFFF_FFFF, 56'h5A5A5A5A5A5A5A, rbyte};

    always #5 clock = ~clock;

    main_mem_loader dut (
        .clock(clock), .reset(reset), .go(go),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .error(error), .cycles(cycles),
        .start_port(start_port), .done_port(done_port),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Core/memory model, evaluated 2 time units after each falling edge.
    always begin
        @(negedge clock);
        #2;
        model_rdy = 1'b0;
        if (reset) begin
            pend = 0; run_cnt = -1; model_done = 1'b0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0 && !pend_blk) model_rdy = 1'b1;
            end
            if (S_we_ram[0] || S_oe_ram[0]) begin
                chk("bus_oe_we_excl", 64'(S_we_ram[0] & S_oe_ram[0]), 64'd0);
                chk("bus_size", 64'(S_data_ram_size[SW-1:0]), 64'd8);
                chk("bus_ch1_zero", {S_oe_ram[1], S_we_ram[1], S_addr_ram[2*AW-1:AW],
                    S_data_ram_size[2*SW-1:SW], |S_Wdata_ram[2*DW-1:DW]}, 64'd0);
                pend = rdy_delay;
                pend_blk = 0;
                if (S_we_ram[0]) begin
                    chk("wr_addr", 64'(S_addr_ram[AW-1:0]), 64'(wr_idx));
                    mem[S_addr_ram[AW-1:0]] = S_Wdata_ram[7:0];
                    pend_blk = (wr_idx == block_wr);
                    wr_idx++;
                end else begin
                    chk("rd_addr", 64'(S_addr_ram[AW-1:0]), 64'(rd_idx));
                    rbyte = mem[S_addr_ram[AW-1:0]];
                    rd_idx++;
                end
            end else if (busy) begin
                chk("bus_idle_zero", 64'({S_addr_ram, S_data_ram_size}), 64'd0);
            end
            if (start_port) run_cnt = 0;
            else if (run_cnt >= 0) run_cnt++;
            model_done = (run_cnt == done_delay);
            if (run_cnt > done_delay) run_cnt = -1;
        end
    end

    task automatic send_byte(input logic [7:0] d, output bit ok);
        in_valid = 1'b1;
        in_data  = d;
        ok       = 0;
        for (int t = 0; t < 64; t++) begin
            if (in_ready) begin ok = 1; break; end
            @(negedge clock);
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic start_pass();
        wr_idx = 0; rd_idx = 0;
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
    endtask

    task automatic load_all(input int pulse_at);
        bit ok;
        for (int k = 0; k < NB; k++) begin
            if (k == pulse_at) begin go = 1'b1; extra_done = 1'b1; end
            send_byte(exp_mem[k], ok);
            go = 1'b0; extra_done = 1'b0;
            chk("load_ready", 64'(ok), 64'd1);
            if (!ok) break;
        end
    endtask

    task automatic recv_all(input bit toggle, input string tag);
        int j = 0;
        bit have = 0;
        bit rdy;
        logic [7:0] held = 8'h00;
        for (int t = 0; t < 4000 && j < NB; t++) begin
            @(negedge clock);
            rdy = toggle ? t[0] : 1'b1;
            out_ready = rdy;
            if (out_valid) begin
                if (have) chk({tag, "_stall_hold"}, 64'(out_data), 64'(held));
                if (rdy) begin
                    chk({tag, "_data"}, 64'(out_data), 64'(exp_mem[j]));
                    chk({tag, "_last"}, 64'(out_last), 64'(j == NB - 1));
                    j++;
                    have = 0;
                end else begin
                    held = out_data;
                    have = 1;
                end
            end
        end
        chk({tag, "_count"}, 64'(j), 64'(NB));
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    initial begin
        bit ok;
        bit seen;
        repeat (3) @(negedge clock);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out", 64'({out_valid, out_last, out_data}), 64'd0);
        chk("rst_start", 64'(start_port), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_cycles", 64'(cycles), 64'd0);
        chk("rst_slave", 64'({S_oe_ram, S_we_ram, S_addr_ram, S_data_ram_size, |S_Wdata_ram}), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // 1: identity pattern, DataRdy after 2 cycles, done 5 cycles after start
        for (int k = 0; k < NB; k++) exp_mem[k] = 8'(k);
        rdy_delay = 2; done_delay = 5;
        start_pass();
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        load_all(-1);
        recv_all(1'b0, "t1");
        chk("t1_writes", 64'(wr_idx), 64'd256);
        chk("t1_reads", 64'(rd_idx), 64'd256);
        chk("t1_cycles", 64'(cycles), 64'd5);
        chk("t1_idle", 64'({busy, error}), 64'd0);

        // 2: done in the first run cycle
        for (int k = 0; k < NB; k++) exp_mem[k] = 8'(255 - k);
        done_delay = 1;
        start_pass();
        load_all(-1);
        recv_all(1'b0, "t2");
        chk("t2_cycles", 64'(cycles), 64'd1);

        // 3: consumer stalls every other cycle
        for (int k = 0; k < NB; k++) exp_mem[k] = 8'(k * 13 + 5);
        done_delay = 3;
        start_pass();
        load_all(-1);
        recv_all(1'b1, "t3");
        chk("t3_cycles", 64'(cycles), 64'd3);
        chk("t3_idle", 64'(busy), 64'd0);

        // 4: write index 3 never acknowledged
        block_wr = 3;
        start_pass();
        for (int k = 0; k < 4; k++) send_byte(8'(k), ok);
        chk("t4_wait_busy", 64'({busy, error, in_ready}), 64'b100);
        repeat (15) @(negedge clock);
        chk("t4_last_wait", 64'({busy, error}), 64'b10);
        @(negedge clock);
        chk("t4_timeout", 64'({busy, error}), 64'b01);
        chk("t4_in_ready", 64'(in_ready), 64'd0);
        block_wr = -1;

        // 6: next go clears error; go and done pulsed during load are ignored
        for (int k = 0; k < NB; k++) exp_mem[k] = 8'(k * 7 + 3);
        done_delay = 7;
        start_pass();
        chk("t6_err_cleared", 64'({busy, error}), 64'b10);
        load_all(10);
        recv_all(1'b0, "t6");
        chk("t6_writes", 64'(wr_idx), 64'd256);
        chk("t6_cycles", 64'(cycles), 64'd7);
        chk("t6_idle", 64'({busy, error}), 64'd0);

        // 5: reset while the core is running
        done_delay = -5;
        start_pass();
        load_all(-1);
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
            if (start_port) seen = 1;
            else @(negedge clock);
        end
        chk("t5_start_seen", 64'(seen), 64'd1);
        repeat (4) @(negedge clock);
        chk("t5_running", 64'({busy, start_port}), 64'b10);
        chk("t5_cycles_run", 64'(cycles), 64'd3);
        reset = 1'b1;
        @(negedge clock);
        chk("t5_rst_state", 64'({busy, start_port, error, out_valid, in_ready}), 64'd0);
        chk("t5_rst_cycles", 64'(cycles), 64'd0);
        chk("t5_rst_slave", 64'({S_oe_ram, S_we_ram, S_addr_ram, S_data_ram_size, |S_Wdata_ram}), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
